// File: rtl/pcount_ctrl.sv
// Queue occupancy counter driven by entry/exit photocells; a passage counts when the beam is restored.
// Define PCOUNT_DEBOUNCE_EN to insert a DB_CYCLES stability filter after each sensor synchronizer.
module pcount_ctrl #(
    parameter int N         = 3,
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         front_sensor,
    input  logic         back_sensor,
    output logic [N-1:0] Pcount,
    output logic         entry_evt,
    output logic         exit_evt,
    output logic         entry_reject,
    output logic         exit_error
);

    if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_bad_db_cycles
        $error("pcount_ctrl: DB_CYCLES must be in 1..15");
    end

    logic [1:0]   r_front_sync;
    logic [1:0]   r_back_sync;
    logic         w_front_lvl;
    logic         w_back_lvl;
    logic         r_front_prev;
    logic         r_back_prev;
    logic         w_front_fall;
    logic         w_back_fall;
    logic [N-1:0] r_pcount;
    logic         r_entry_evt;
    logic         r_exit_evt;
    logic         r_entry_reject;
    logic         r_exit_error;
    logic [N-1:0] w_pcount_nxt;
    logic         w_entry_nxt;
    logic         w_exit_nxt;
    logic         w_reject_nxt;
    logic         w_error_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_front_sync <= '0;
            r_back_sync  <= '0;
        end else begin
            r_front_sync <= {r_front_sync[0], front_sensor};
            r_back_sync  <= {r_back_sync[0], back_sensor};
        end
    end

`ifdef PCOUNT_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    logic       r_front_db;
    logic       r_back_db;
    logic [3:0] r_front_cnt;
    logic [3:0] r_back_cnt;

    // The filtered level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_front_db  <= 1'b0;
            r_back_db   <= 1'b0;
            r_front_cnt <= '0;
            r_back_cnt  <= '0;
        end else begin
            if (r_front_sync[1] == r_front_db) begin
                r_front_cnt <= '0;
            end else if (r_front_cnt == DB_LAST) begin
                r_front_db  <= r_front_sync[1];
                r_front_cnt <= '0;
            end else begin
                r_front_cnt <= r_front_cnt + 4'd1;
            end
            if (r_back_sync[1] == r_back_db) begin
                r_back_cnt <= '0;
            end else if (r_back_cnt == DB_LAST) begin
                r_back_db  <= r_back_sync[1];
                r_back_cnt <= '0;
            end else begin
                r_back_cnt <= r_back_cnt + 4'd1;
            end
        end
    end

    assign w_front_lvl = r_front_db;
    assign w_back_lvl  = r_back_db;
`else
    assign w_front_lvl = r_front_sync[1];
    assign w_back_lvl  = r_back_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_front_prev <= 1'b0;
            r_back_prev  <= 1'b0;
        end else begin
            r_front_prev <= w_front_lvl;
            r_back_prev  <= w_back_lvl;
        end
    end

    assign w_front_fall = r_front_prev & ~w_front_lvl;
    assign w_back_fall  = r_back_prev & ~w_back_lvl;

    // Simultaneous entry and exit cancel: count holds and no pulse is raised.
    always_comb begin
        w_pcount_nxt = r_pcount;
        w_entry_nxt  = 1'b0;
        w_exit_nxt   = 1'b0;
        w_reject_nxt = 1'b0;
        w_error_nxt  = 1'b0;
        if (w_front_fall && !w_back_fall) begin
            if (r_pcount == '1) begin
                w_reject_nxt = 1'b1;
            end else begin
                w_pcount_nxt = r_pcount + N'(1);
                w_entry_nxt  = 1'b1;
            end
        end else if (w_back_fall && !w_front_fall) begin
            if (r_pcount == '0) begin
                w_error_nxt = 1'b1;
            end else begin
                w_pcount_nxt = r_pcount - N'(1);
                w_exit_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcount       <= '0;
            r_entry_evt    <= 1'b0;
            r_exit_evt     <= 1'b0;
            r_entry_reject <= 1'b0;
            r_exit_error   <= 1'b0;
        end else begin
            r_pcount       <= w_pcount_nxt;
            r_entry_evt    <= w_entry_nxt;
            r_exit_evt     <= w_exit_nxt;
            r_entry_reject <= w_reject_nxt;
            r_exit_error   <= w_error_nxt;
        end
    end

    assign Pcount       = r_pcount;
    assign entry_evt    = r_entry_evt;
    assign exit_evt     = r_exit_evt;
    assign entry_reject = r_entry_reject;
    assign exit_error   = r_exit_error;

endmodule

// File: tb/tb_pcount_ctrl.sv
// Bench for pcount_ctrl: directed passages plus random sensor activity against a sample-history model.
module tb_pcount_ctrl;
    localparam int N    = 3;
    localparam int DBP  = 4;
`ifdef PCOUNT_DEBOUNCE_EN
    localparam int DBM  = DBP;
    localparam int LAT  = 3;
`else
    localparam int DBM  = 1;
    localparam int LAT  = 2;
`endif
    localparam int MAXV = (1 << N) - 1;
    localparam int HSZ  = 8192;
    localparam int GAP  = LAT + DBM + 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         front_sensor = 1'b0;
    logic         back_sensor = 1'b0;
    logic [N-1:0] Pcount;
    logic         entry_evt;
    logic         exit_evt;
    logic         entry_reject;
    logic         exit_error;

    pcount_ctrl #(.N(N), .DB_CYCLES(DBP)) dut (
        .clk(clk),
        .reset(reset),
        .front_sensor(front_sensor),
        .back_sensor(back_sensor),
        .Pcount(Pcount),
        .entry_evt(entry_evt),
        .exit_evt(exit_evt),
        .entry_reject(entry_reject),
        .exit_error(exit_error)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   e       = 32;
    // Sensor samples and the (possibly filtered) levels they produce, per clock edge.
    logic sf[HSZ];
    logic sb[HSZ];
    logic lf[HSZ];
    logic lb[HSZ];
    int   m_p = 0;
    logic m_ent, m_ext, m_rej, m_err;
    int   n_ent = 0, n_ext = 0, n_rej = 0, n_err = 0;
    int   base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Level toggles once the last DBM samples all disagree with it.
    function automatic logic next_level(input bit back);
        logic prev;
        logic flip;
        prev = back ? lb[e-1] : lf[e-1];
        flip = 1'b1;
        for (int j = e - DBM + 1; j <= e; j++) begin
            if ((back ? sb[j] : sf[j]) == prev) flip = 1'b0;
        end
        return flip ? ~prev : prev;
    endfunction

    task automatic tick(input logic f, input logic b, input logic r);
        int  k;
        logic fe, be;
        @(negedge clk);
        front_sensor = f;
        back_sensor  = b;
        reset        = r;
        @(posedge clk);
        e++;
        if (e >= HSZ - 1) begin
            $display("FAIL history_bound: observed %0d expected below %0d", e, HSZ - 1);
            $fatal(1, "history exhausted");
        end
        m_ent = 1'b0; m_ext = 1'b0; m_rej = 1'b0; m_err = 1'b0;
        if (r) begin
            for (int j = e - 20; j <= e; j++) begin
                sf[j] = 1'b0; sb[j] = 1'b0; lf[j] = 1'b0; lb[j] = 1'b0;
            end
            m_p = 0;
        end else begin
            sf[e] = f;
            sb[e] = b;
            lf[e] = next_level(1'b0);
            lb[e] = next_level(1'b1);
            k  = e - LAT;
            fe = lf[k-1] & ~lf[k];
            be = lb[k-1] & ~lb[k];
            if (fe && !be) begin
                if (m_p == MAXV) m_rej = 1'b1;
                else begin m_p++; m_ent = 1'b1; end
            end else if (be && !fe) begin
                if (m_p == 0) m_err = 1'b1;
                else begin m_p--; m_ext = 1'b1; end
            end
        end
        #1;
        n_ent += int'(entry_evt);
        n_ext += int'(exit_evt);
        n_rej += int'(entry_reject);
        n_err += int'(exit_error);
        chk("pcount", 32'(Pcount), 32'(m_p));
        chk("entry_evt", 32'(entry_evt), 32'(m_ent));
        chk("exit_evt", 32'(exit_evt), 32'(m_ext));
        chk("entry_reject", 32'(entry_reject), 32'(m_rej));
        chk("exit_error", 32'(exit_error), 32'(m_err));
    endtask

    task automatic run(input logic f, input logic b, input logic r, input int n);
        for (int i = 0; i < n; i++) tick(f, b, r);
    endtask

    task automatic pass(input logic f, input logic b, input int times);
        for (int i = 0; i < times; i++) begin
            run(f, b, 1'b0, 5);
            run(1'b0, 1'b0, 1'b0, GAP);
        end
    endtask

    initial begin
        for (int j = 0; j < HSZ; j++) begin
            sf[j] = 1'b0; sb[j] = 1'b0; lf[j] = 1'b0; lb[j] = 1'b0;
        end

        run(1'b0, 1'b0, 1'b1, 3);
        chk("reset_pcount", 32'(Pcount), 32'd0);

        base = n_ent;
        pass(1'b1, 1'b0, 3);
        chk("three_entries_pcount", 32'(Pcount), 32'd3);
        chk("three_entries_pulses", 32'(n_ent - base), 32'd3);

        pass(1'b1, 1'b0, 4);
        chk("fill_pcount", 32'(Pcount), 32'd7);
        base = n_ent;
        n_rej = 0;
        pass(1'b1, 1'b0, 1);
        chk("saturate_pcount", 32'(Pcount), 32'd7);
        chk("saturate_reject", 32'(n_rej), 32'd1);
        chk("saturate_no_entry", 32'(n_ent - base), 32'd0);

        pass(1'b1, 1'b1, 1);
        chk("both_at_max", 32'(Pcount), 32'd7);
        pass(1'b0, 1'b1, 3);
        chk("down_to_4", 32'(Pcount), 32'd4);
        pass(1'b1, 1'b1, 1);
        chk("both_at_4", 32'(Pcount), 32'd4);
        pass(1'b0, 1'b1, 4);
        chk("down_to_0", 32'(Pcount), 32'd0);

        n_err = 0;
        pass(1'b0, 1'b1, 1);
        chk("underflow_pcount", 32'(Pcount), 32'd0);
        chk("underflow_error", 32'(n_err), 32'd1);
        pass(1'b1, 1'b1, 1);
        chk("both_at_0", 32'(Pcount), 32'd0);

        pass(1'b1, 1'b0, 2);
        base = n_ext;
        pass(1'b0, 1'b1, 1);
        chk("exit_from_2", 32'(Pcount), 32'd1);
        chk("exit_pulse", 32'(n_ext - base), 32'd1);

        run(1'b1, 1'b0, 1'b0, 3);
        run(1'b1, 1'b0, 1'b1, 2);
        run(1'b1, 1'b0, 1'b0, 8);
        run(1'b0, 1'b0, 1'b0, GAP);
        chk("reset_mid_passage", 32'(Pcount), 32'd1);
        run(1'b0, 1'b0, 1'b1, 2);
        run(1'b0, 1'b0, 1'b0, GAP);
        chk("low_across_reset", 32'(Pcount), 32'd0);

        run(1'b1, 1'b0, 1'b0, 10);
        run(1'b0, 1'b0, 1'b0, 1);
        run(1'b1, 1'b0, 1'b0, 10);
        run(1'b0, 1'b0, 1'b0, GAP);
`ifdef PCOUNT_DEBOUNCE_EN
        chk("glitch_filtered", 32'(Pcount), 32'd1);
`else
        chk("glitch_counted", 32'(Pcount), 32'd2);
`endif

        for (int i = 0; i < 250; i++) begin
            logic f, b, r;
            f = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? f : 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 39) == 0);
            run(f, b, r, $urandom_range(1, 8));
        end
        run(1'b0, 1'b0, 1'b0, GAP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pcount_ctrl.md
PCOUNT_CTRL -- requirements
Module: pcount_ctrl

Interface
REQ-001 Parameter N, default 3: width of the occupancy count Pcount.
REQ-002 Parameter DB_CYCLES, default 4: number of consecutive stable cycles the debounce filter requires (range 1-15).
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 front_sensor  input  1  entry photocell, asynchronous; 1 = beam blocked.
REQ-006 back_sensor  input  1  exit (served) photocell, asynchronous; 1 = beam blocked.
REQ-007 Pcount  output  N  registered number of people currently in the queue.
REQ-008 entry_evt  output  1  one-cycle pulse when an accepted entry changes Pcount.
REQ-009 exit_evt  output  1  one-cycle pulse when an accepted exit changes Pcount.
REQ-010 entry_reject  output  1  one-cycle pulse when an entry is seen while Pcount is all ones.
REQ-011 exit_error  output  1  one-cycle pulse when an exit is seen while Pcount is 0.

Function
REQ-012 Each sensor SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 A passage SHALL be detected on the falling edge (1->0) of the conditioned sensor, i.e. when the beam is restored; a rising edge SHALL produce no event.
REQ-014 Entry event alone, Pcount < 2^N-1: Pcount SHALL increment by 1 and entry_evt SHALL pulse.
REQ-015 Entry event alone, Pcount = 2^N-1: Pcount SHALL hold (saturate, no wrap to 0) and entry_reject SHALL pulse.
REQ-016 Exit event alone, Pcount > 0: Pcount SHALL decrement by 1 and exit_evt SHALL pulse.
REQ-017 Exit event alone, Pcount = 0: Pcount SHALL hold (no wrap to all ones) and exit_error SHALL pulse.
REQ-018 Entry and exit events in the same cycle: Pcount SHALL hold at any value, including 0 and 2^N-1, and none of the four pulse outputs SHALL assert.
REQ-019 Without debounce, a sensor falling edge sampled at clock edge k SHALL update Pcount and assert the pulse outputs at edge k+2; pulses SHALL last exactly one cycle.
REQ-020 At most one event per sensor SHALL be produced per falling edge, regardless of how long the sensor stays low.
REQ-021 All outputs SHALL be registered; no combinational path from sensors to outputs.

Reset
REQ-022 While reset is high: Pcount = 0; entry_evt, exit_evt, entry_reject, exit_error = 0; synchronizer, edge and debounce state cleared to the "beam clear" (0) level.
REQ-023 Reset asserted mid-passage (sensor held 1) SHALL discard that passage; after reset releases, the sensor's subsequent 1->0 transition SHALL count normally.
REQ-024 A sensor already low when reset releases SHALL NOT generate an event.

Configuration
REQ-025 Macro PCOUNT_DEBOUNCE_EN: when defined, each synchronized sensor SHALL feed a debounce filter whose output changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles; the event timing of REQ-019 SHALL be delayed by DB_CYCLES cycles, and any glitch shorter than DB_CYCLES cycles SHALL be ignored.
REQ-026 When PCOUNT_DEBOUNCE_EN is not defined, the filter SHALL be absent and the edge detector SHALL take the synchronized sensor directly.

Verification
REQ-027 Reset, then 3 front_sensor pulses (1 for 5 cycles, then 0) -> Pcount 0->1->2->3, three entry_evt pulses, each 2 cycles after the sampled fall (no debounce).
REQ-028 N=3, Pcount=7, front pulse -> Pcount stays 7, entry_reject pulses once, entry_evt stays 0.
REQ-029 Pcount=0, back pulse -> Pcount stays 0, exit_error pulses once; then Pcount=2, back pulse -> Pcount 1, exit_evt pulses once.
REQ-030 Pcount=4, front and back falling in the same cycle -> Pcount stays 4, no pulse outputs; repeat at Pcount=0 and 7 -> same result.
REQ-031 With PCOUNT_DEBOUNCE_EN, DB_CYCLES=4: front 1-cycle-low glitch during a blocked period -> no event; clean pulse -> Pcount +1 exactly 6 cycles after the sampled fall.
REQ-032 Front held 1, reset for 2 cycles, front released after reset -> Pcount 1 after release; front held 0 across reset release -> Pcount stays 0.
